// File: rtl/rounding_pipe_pkg.sv
// Shared definitions for the rounding pipeline: rounding mode encodings
// and the count of fraction bits discarded when narrowing a lane.
// Imported by rounding_lane and rounding_pipe.
package rounding_pipe_pkg;

    localparam logic [1:0] RND_TRUNC   = 2'd0;  // floor
    localparam logic [1:0] RND_HALF_UP = 2'd1;  // round half toward +inf
    localparam logic [1:0] RND_CONV    = 2'd2;  // round half to even
    localparam logic [1:0] RND_AWAY    = 2'd3;  // round half away from zero

    // Number of low-order bits dropped when narrowing in_w to out_w.
    function automatic int rnd_frac_bits(input int in_w, input int out_w);
        return in_w - out_w;
    endfunction

endpackage

// File: rtl/rounding_lane.sv
// One lane of the rounder: stage-1 addend/sum and stage-2 shift/saturate.
// Purely combinational, no latency of its own.
// No flow control here; the parent pipeline owns registers and handshake.
module rounding_lane
    import rounding_pipe_pkg::*;
#(
    parameter int IN_W   = 13,
    parameter int OUT_W  = 10,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic [IN_W-1:0]  x,
    input  logic [1:0]       mode,
    output logic [IN_W:0]    sum,
    input  logic [IN_W:0]    sum_q,
    output logic [OUT_W-1:0] y,
    output logic             ovf
);

    localparam int D = rnd_frac_bits(IN_W, OUT_W);

    // Half of one output LSB, expressed at input resolution.
    localparam logic [IN_W:0] HALF = {{(IN_W+1-D){1'b0}}, 1'b1, {(D-1){1'b0}}};

    // Largest representable output: 0 1..1 for signed, all ones for unsigned.
    localparam logic [OUT_W-1:0] CLAMP = (SIGNED != 0) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                       : {OUT_W{1'b1}};

    logic [IN_W:0]  ext;
    logic [IN_W:0]  addend;
    logic           neg;
    logic [OUT_W:0] r;
    logic           unused_frac;

    // Stage-1 function: pick the rounding addend and add it to the widened input.
    always_comb begin
        ext    = (SIGNED != 0) ? {x[IN_W-1], x} : {1'b0, x};
        neg    = (SIGNED != 0) && x[IN_W-1];
        addend = '0;
        case (mode)
            RND_TRUNC:   addend = '0;
            RND_HALF_UP: addend = HALF;
            // Kept bit odd -> a tie rounds up to even; kept bit even -> a tie stays.
            RND_CONV:    addend = x[D] ? HALF : HALF - 1'b1;
            // Negative ties must move toward -inf, so stop one short of half.
            RND_AWAY:    addend = neg ? HALF - 1'b1 : HALF;
        endcase
        sum = ext + addend;
    end

    // Fraction bits only matter before the shift; they are intentionally dropped.
    assign unused_frac = ^sum_q[D-1:0];

    // Stage-2 function: drop the fraction, detect overflow, optionally clamp.
    always_comb begin
        r   = sum_q[IN_W:D];
        ovf = (SIGNED != 0) ? (r[OUT_W] != r[OUT_W-1]) : r[OUT_W];
        y   = ((SAT != 0) && ovf) ? CLAMP : r[OUT_W-1:0];
    end

endmodule

// File: rtl/rounding_pipe.sv
// Multi-lane fixed-point narrowing rounder with selectable mode and optional saturation.
// Latency: 2 cycles from input handshake to o_valid; one beat per cycle throughput.
// Backpressure: each stage advances when it is empty or the stage after it frees; i_ready has no bubble.
module rounding_pipe
    import rounding_pipe_pkg::*;
#(
    parameter int IN_W   = 13,
    parameter int OUT_W  = 10,
    parameter int LANES  = 4,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [LANES*IN_W-1:0]  i_data,
    input  logic [1:0]             i_mode,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [LANES*OUT_W-1:0] o_data,
    output logic [LANES-1:0]       o_sat,
    output logic                   o_sat_sticky,
    input  logic                   i_clr_sticky
);

    if (rnd_frac_bits(IN_W, OUT_W) < 2) begin : g_bad_widths
        $error("rounding_pipe: IN_W - OUT_W must be at least 2");
    end

    logic                   s1_valid;
    logic [IN_W:0]          s1_sum   [LANES];
    logic [IN_W:0]          sum_next [LANES];
    logic [LANES*OUT_W-1:0] data_next;
    logic [LANES-1:0]       sat_next;
    logic                   s1_en;
    logic                   s2_en;

    assign s2_en   = !o_valid || o_ready;
    assign s1_en   = !s1_valid || s2_en;
    assign i_ready = s1_en;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        rounding_lane #(
            .IN_W   (IN_W),
            .OUT_W  (OUT_W),
            .SIGNED (SIGNED),
            .SAT    (SAT)
        ) u_lane (
            .x     (i_data[k*IN_W +: IN_W]),
            .mode  (i_mode),
            .sum   (sum_next[k]),
            .sum_q (s1_sum[k]),
            .y     (data_next[k*OUT_W +: OUT_W]),
            .ovf   (sat_next[k])
        );
    end

    // Stage 1: capture the rounded-up sums; the mode is consumed here so later changes cannot reach this beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                s1_sum[k] <= '0;
            end
        end else if (s1_en) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                for (int k = 0; k < LANES; k++) begin
                    s1_sum[k] <= sum_next[k];
                end
            end
        end
    end

    // Stage 2: output register; holds data and flags while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= '0;
        end else if (s2_en) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data <= data_next;
                o_sat  <= sat_next;
            end
        end
    end

    // Sticky overflow: set as a saturating beat enters stage 2; a clear on the same edge wins.
    always_ff @(posedge clk) begin
        if (reset || i_clr_sticky) begin
            o_sat_sticky <= 1'b0;
        end else if (s2_en && s1_valid && (|sat_next)) begin
            o_sat_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rounding_pipe.sv
// Scoreboard bench for rounding_pipe: driver pushes expected beats at handshake,
// a negedge monitor pops and compares, checks latency, stall stability and i_ready.
// Expected values come from an integer-arithmetic rounding model.
module tb_rounding_pipe;

    localparam int IN_W  = 13;
    localparam int OUT_W = 10;
    localparam int LANES = 4;
    localparam int D     = IN_W - OUT_W;

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        logic [LANES-1:0]       sat;
        int                     acc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   i_valid;
    logic                   i_ready;
    logic [LANES*IN_W-1:0]  i_data;
    logic [1:0]             i_mode;
    logic                   o_valid;
    logic                   o_ready;
    logic [LANES*OUT_W-1:0] o_data;
    logic [LANES-1:0]       o_sat;
    logic                   o_sat_sticky;
    logic                   i_clr_sticky;

    // single-lane auxiliary builds: SAT=0 (n_*) and SIGNED=0 (u_*)
    logic             n_iv, n_ir, n_ov, n_os, n_st;
    logic [IN_W-1:0]  n_id;
    logic [1:0]       n_im;
    logic [OUT_W-1:0] n_od;
    logic             u_iv, u_ir, u_ov, u_os, u_st;
    logic [IN_W-1:0]  u_id;
    logic [1:0]       u_im;
    logic [OUT_W-1:0] u_od;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   rmode = 0;
    int   pat_idx = 0;
    int   last_low = -1;
    bit   chk_sticky = 1'b1;
    bit   ovr = 1'b0;
    logic [OUT_W-1:0] ovr_y = '0;
    bit   ovr_s = 1'b0;
    exp_t sb[$];
    bit   stalled = 1'b0;
    logic [LANES*OUT_W-1:0] held_d;
    logic [LANES-1:0]       held_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rounding_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .SIGNED(1), .SAT(1)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .i_mode(i_mode), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_sat(o_sat),
        .o_sat_sticky(o_sat_sticky), .i_clr_sticky(i_clr_sticky));

    rounding_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(1), .SIGNED(1), .SAT(0)) u_nosat (
        .clk(clk), .reset(reset), .i_valid(n_iv), .i_ready(n_ir), .i_data(n_id),
        .i_mode(n_im), .o_valid(n_ov), .o_ready(1'b1), .o_data(n_od), .o_sat(n_os),
        .o_sat_sticky(n_st), .i_clr_sticky(1'b0));

    rounding_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(1), .SIGNED(0), .SAT(1)) u_uns (
        .clk(clk), .reset(reset), .i_valid(u_iv), .i_ready(u_ir), .i_data(u_id),
        .i_mode(u_im), .o_valid(u_ov), .o_ready(1'b1), .o_data(u_od), .o_sat(u_os),
        .o_sat_sticky(u_st), .i_clr_sticky(1'b0));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floordiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // Rounding reference: value -> rounded integer -> range check -> output bits.
    function automatic void ref_round(input int x_raw, input int mode, input bit sgn,
                                      input bit sat, output int y, output bit ovf);
        int v, q, p, half, rem, maxv;
        p    = 1 << D;
        half = p / 2;
        v    = (sgn && x_raw[IN_W-1]) ? x_raw - (1 << IN_W) : x_raw;
        case (mode)
            0: q = floordiv(v, p);
            1: q = floordiv(v + half, p);
            2: begin
                q   = floordiv(v, p);
                rem = v - q * p;
                if (rem > half || (rem == half && (q & 1) != 0)) q = q + 1;
            end
            default: q = (v >= 0) ? (v + half) / p : -((-v + half) / p);
        endcase
        maxv = sgn ? (1 << (OUT_W - 1)) - 1 : (1 << OUT_W) - 1;
        ovf  = q > maxv;
        if (ovf && sat) q = maxv;
        y = q & ((1 << OUT_W) - 1);
    endfunction

    // downstream ready generator: 0 always, 1 random, 2 fixed pattern, 3 never
    initial begin
        bit pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: o_ready = 1'b1;
                1: o_ready = ($urandom_range(0, 3) != 0);
                2: begin o_ready = pat[pat_idx % 7]; pat_idx++; end
                default: o_ready = 1'b0;
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        exp_t e;
        int   y;
        bit   o;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                stalled = 1'b0;
            end else begin
                chk("i_ready", i_ready, !(sb.size() == 2 && !o_ready));
                if (stalled) begin
                    chk("stall_valid", o_valid, 1'b1);
                    chk("stall_data", o_data, held_d);
                    chk("stall_sat", o_sat, held_s);
                end
                if (!o_ready) last_low = cyc;
                if (sb.size() == 0) begin
                    chk("no_stale", o_valid, 1'b0);
                end else if (o_valid && o_ready) begin
                    e = sb.pop_front();
                    chk("data", o_data, e.data);
                    chk("sat", o_sat, e.sat);
                    if (last_low < e.acc) chk("latency", cyc - e.acc, 2);
                    if (chk_sticky && e.sat != '0) chk("sticky_set", o_sat_sticky, 1'b1);
                end
                stalled = o_valid && !o_ready;
                held_d  = o_data;
                held_s  = o_sat;
                if (i_valid && i_ready) begin
                    for (int k = 0; k < LANES; k++) begin
                        ref_round(int'(i_data[k*IN_W +: IN_W]), int'(i_mode), 1'b1, 1'b1, y, o);
                        e.data[k*OUT_W +: OUT_W] = y[OUT_W-1:0];
                        e.sat[k] = o;
                    end
                    if (ovr) begin
                        e.data[OUT_W-1:0] = ovr_y;
                        e.sat[0] = ovr_s;
                    end
                    e.acc = cyc;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [LANES*IN_W-1:0] d, input logic [1:0] m,
                        input bit ov, input logic [OUT_W-1:0] y0, input bit s0);
        int t;
        @(posedge clk);
        #1;
        i_valid = 1'b1; i_data = d; i_mode = m;
        ovr = ov; ovr_y = y0; ovr_s = s0;
        t = 0;
        forever begin
            @(negedge clk);
            if (i_ready) break;
            t++;
            if (t > 200) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout: i_ready stuck low for %0d cycles", t);
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        ovr = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    function automatic logic [IN_W-1:0] rnd_lane();
        case ($urandom_range(0, 3))
            0: return 13'h0FF8 + IN_W'($urandom_range(0, 7));
            1: return 13'h1000 + IN_W'($urandom_range(0, 7));
            default: return IN_W'($urandom);
        endcase
    endfunction

    task automatic aux_beat(input logic [IN_W-1:0] xn, input logic [1:0] mn,
                            input logic [IN_W-1:0] xu, input logic [1:0] mu);
        int yn, yu;
        bit on, ou;
        @(posedge clk);
        #1;
        chk("nosat_rdy", n_ir, 1'b1);
        chk("uns_rdy", u_ir, 1'b1);
        n_iv = 1'b1; n_id = xn; n_im = mn;
        u_iv = 1'b1; u_id = xu; u_im = mu;
        @(posedge clk);
        #1;
        n_iv = 1'b0; u_iv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ref_round(int'(xn), int'(mn), 1'b1, 1'b0, yn, on);
        ref_round(int'(xu), int'(mu), 1'b0, 1'b1, yu, ou);
        chk("nosat_valid", n_ov, 1'b1);
        chk("nosat_data", n_od, yn[OUT_W-1:0]);
        chk("nosat_sat", n_os, on);
        chk("uns_valid", u_ov, 1'b1);
        chk("uns_data", u_od, yu[OUT_W-1:0]);
        chk("uns_sat", u_os, ou);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0]       dx [12];
        logic [1:0]            dm [12];
        logic [OUT_W-1:0]      dy [12];
        bit                    ds [12];
        logic [LANES*IN_W-1:0] d;

        dx = '{13'h00C, 13'h014, 13'h01C, 13'h1FEC, 13'h014, 13'h014, 13'h014,
               13'h1FEC, 13'h1FEC, 13'h1FEC, 13'h0FFF, 13'h0FFF};
        dm = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0};
        dy = '{10'h002, 10'h002, 10'h004, 10'h3FE, 10'h002, 10'h003, 10'h003,
               10'h3FE, 10'h3FD, 10'h3FD, 10'h1FF, 10'h1FF};
        ds = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

        reset = 1'b1; i_valid = 1'b0; i_data = '0; i_mode = '0; i_clr_sticky = 1'b0;
        n_iv = 1'b0; n_id = '0; n_im = '0; u_iv = 1'b0; u_id = '0; u_im = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_i_ready", i_ready, 1'b1);
        chk("rst_sticky", o_sat_sticky, 1'b0);
        chk("rst_o_data", o_data, '0);
        chk("rst_o_sat", o_sat, '0);

        // directed lane-0 vectors streamed back to back, other lanes random
        for (int i = 0; i < 12; i++) begin
            d = '0;
            for (int k = 1; k < LANES; k++) d[k*IN_W +: IN_W] = IN_W'($urandom_range(0, 2047));
            d[IN_W-1:0] = dx[i];
            send(d, dm[i], 1'b1, dy[i], ds[i]);
        end
        idle();
        drain();
        chk("sticky_after_sat", o_sat_sticky, 1'b1);

        // random beats, random modes, random gaps, random downstream stalls
        rmode = 1;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = rnd_lane();
            send(d, 2'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();
        rmode = 0;
        drain();

        // fixed backpressure pattern over six consecutive beats
        pat_idx = 0;
        rmode = 2;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
            send(d, 2'(i % 4), 1'b0, '0, 1'b0);
        end
        idle();
        drain();
        rmode = 0;

        // sticky clear beats a simultaneous set
        chk_sticky = 1'b0;
        @(posedge clk); #1 i_clr_sticky = 1'b1;
        @(posedge clk); #1 i_clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", o_sat_sticky, 1'b0);
        d = '0;
        d[IN_W-1:0] = 13'h0FFF;
        send(d, 2'd2, 1'b0, '0, 1'b0);
        @(posedge clk); #1 i_valid = 1'b0; i_clr_sticky = 1'b1;
        @(posedge clk); #1 i_clr_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_clr_wins", o_sat_sticky, 1'b0);
        drain();
        send(d, 2'd2, 1'b0, '0, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        chk("sticky_reset_again", o_sat_sticky, 1'b1);
        drain();
        chk_sticky = 1'b1;

        // reset with two beats stalled in flight
        rmode = 3;
        for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = 13'h0FFF;
        send(d, 2'd2, 1'b0, '0, 1'b0);
        send(d, 2'd1, 1'b0, '0, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        chk("pre_reset_sticky", o_sat_sticky, 1'b1);
        chk("pre_reset_full", i_ready, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; rmode = 0;
        @(negedge clk);
        chk("mid_rst_o_valid", o_valid, 1'b0);
        chk("mid_rst_i_ready", i_ready, 1'b1);
        chk("mid_rst_sticky", o_sat_sticky, 1'b0);
        repeat (10) @(negedge clk);

        // auxiliary builds: SAT=0 wraps, SIGNED=0 clamps to all ones
        aux_beat(13'h0FFF, 2'd2, 13'h1FFF, 2'd1);
        chk("nosat_wrap", n_od, 10'h200);
        chk("nosat_flag", n_os, 1'b1);
        chk("uns_clamp", u_od, 10'h3FF);
        chk("uns_flag", u_os, 1'b1);
        for (int i = 0; i < 30; i++) begin
            aux_beat(rnd_lane(), 2'($urandom_range(0, 3)), IN_W'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
